// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: datapath width, writeback select codes
// and load funct3 encodings used by the writeback stage.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load formatter: picks byte/half/word from a little-endian aligned word.
// Ports: word_i, lane_i, funct3_i -> data_o (extended), err_o (misaligned/illegal).
module load_align
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      lane_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (lane_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{24{byte_v[7]}}, byte_v};
      F3_LBU: data_o = {24'h0, byte_v};
      F3_LH: begin
        data_o = {{16{half_v[15]}}, half_v};
        err_o  = lane_i[0];
      end
      F3_LHU: begin
        data_o = {16'h0, half_v};
        err_o  = lane_i[0];
      end
      F3_LW: begin
        data_o = word_i;
        err_o  = (lane_i != 2'd0);
      end
      // 011, 110, 111 are not RV32I loads
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback: MEM/WB register, result mux, x0 guard, instret.
// Ports: WrClk/Rst, stall/flush, mem_* from MEM -> Rw/busW/RegWr, misalign_err, instret.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             WrClk,
  input  logic             Rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_wr,
  input  logic [1:0]       mem_wb_sel,
  input  logic [XLEN-1:0]  mem_alu_res,
  input  logic [XLEN-1:0]  mem_pc4,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [2:0]       mem_funct3,
  output logic             wb_valid,
  output logic [4:0]       Rw,
  output logic [XLEN-1:0]  busW,
  output logic             RegWr,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [4:0]       rd_q, rd_d;
  logic             reg_wr_q, reg_wr_d;
  logic [1:0]       sel_q, sel_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic [XLEN-1:0]  ld_q, ld_d;
  logic [2:0]       f3_q, f3_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  ld_fmt;
  logic             ld_err;
  logic             retire;

  load_align u_align (
    .word_i   (ld_q),
    .lane_i   (alu_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_fmt),
    .err_o    (ld_err)
  );

  assign misalign_err = valid_q & (sel_q == rv32i_pkg::WB_LOAD) & ld_err;

  // done_q marks an instruction already written while held by a stall
  assign retire = valid_q & ~done_q & ~misalign_err & ~flush;

  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    rd_d      = rd_q;
    reg_wr_d  = reg_wr_q;
    sel_d     = sel_q;
    alu_d     = alu_q;
    pc4_d     = pc4_q;
    ld_d      = ld_q;
    f3_d      = f3_q;
    instret_d = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
    if (flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (stall) begin
      done_d = valid_q;
    end else begin
      valid_d  = mem_valid;
      done_d   = 1'b0;
      rd_d     = mem_rd;
      reg_wr_d = mem_reg_wr;
      sel_d    = mem_wb_sel;
      alu_d    = mem_alu_res;
      pc4_d    = mem_pc4;
      ld_d     = mem_load_data;
      f3_d     = mem_funct3;
    end
  end

  always_ff @(posedge WrClk or posedge Rst) begin
    if (Rst) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= '0;
      reg_wr_q  <= 1'b0;
      sel_q     <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
      ld_q      <= '0;
      f3_q      <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      reg_wr_q  <= reg_wr_d;
      sel_q     <= sel_d;
      alu_q     <= alu_d;
      pc4_q     <= pc4_d;
      ld_q      <= ld_d;
      f3_q      <= f3_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    busW = '0;
    if (valid_q) begin
      case (sel_q)
        rv32i_pkg::WB_LOAD: busW = ld_fmt;
        rv32i_pkg::WB_PC4:  busW = pc4_q;
        default:            busW = alu_q;
      endcase
    end
  end

  assign wb_valid = valid_q;
  assign Rw       = rd_q;
  assign RegWr    = valid_q & reg_wr_q & (rd_q != 5'd0)
                  & ~misalign_err & ~done_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with an expectation queue per cycle
// and a small retire model for instret.
module tb_wb_stage;

  logic        WrClk = 1'b0;
  logic        Rst;
  logic        stall, flush;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_reg_wr;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_res, mem_pc4, mem_load_data;
  logic [2:0]  mem_funct3;
  logic        wb_valid;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic        RegWr;
  logic        misalign_err;
  logic [63:0] instret;

  wb_stage dut (
    .WrClk         (WrClk),
    .Rst           (Rst),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_reg_wr    (mem_reg_wr),
    .mem_wb_sel    (mem_wb_sel),
    .mem_alu_res   (mem_alu_res),
    .mem_pc4       (mem_pc4),
    .mem_load_data (mem_load_data),
    .mem_funct3    (mem_funct3),
    .wb_valid      (wb_valid),
    .Rw            (Rw),
    .busW          (busW),
    .RegWr         (RegWr),
    .misalign_err  (misalign_err),
    .instret       (instret)
  );

  always #5 WrClk = ~WrClk;

  typedef struct {
    string       tag;
    logic        valid;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // reference model of WB occupancy for instret
  logic        m_valid = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [63:0] exp_ret = '0;

  localparam logic [31:0] WORD = 32'h80FF7F01;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd,
                       input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] ld, input logic [2:0] f3,
                       input logic st, input logic fl);
    mem_valid     = v;
    mem_rd        = rd;
    mem_reg_wr    = rw;
    mem_wb_sel    = sel;
    mem_alu_res   = alu;
    mem_pc4       = pc4;
    mem_load_data = ld;
    mem_funct3    = f3;
    stall         = st;
    flush         = fl;
  endtask

  task automatic push(input string tag, input logic v, input logic wr,
                      input logic [4:0] rw, input logic [31:0] bw,
                      input logic err);
    exp_t e;
    e.tag = tag; e.valid = v; e.regwr = wr;
    e.rw = rw; e.busw = bw; e.err = err;
    q.push_back(e);
  endtask

  // one clock edge with the currently driven inputs, then compare
  task automatic tick();
    exp_t e;
    e = q.pop_front();
    if (m_valid && !m_done && !m_err && !flush) exp_ret++;
    if (flush) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
    end else if (stall) begin
      m_done = m_valid;
    end else begin
      m_valid = mem_valid;
      m_done  = 1'b0;
      m_err   = e.err;
    end
    @(posedge WrClk);
    #1;
    chk({e.tag, ".wb_valid"}, 64'(wb_valid), 64'(e.valid));
    chk({e.tag, ".RegWr"}, 64'(RegWr), 64'(e.regwr));
    chk({e.tag, ".misalign"}, 64'(misalign_err), 64'(e.err));
    if (e.valid) chk({e.tag, ".Rw"}, 64'(Rw), 64'(e.rw));
    chk({e.tag, ".busW"}, 64'(busW), 64'(e.busw));
    chk({e.tag, ".instret"}, instret, exp_ret);
  endtask

  initial begin
    Rst = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0);
    #3;
    chk("rst.wb_valid", 64'(wb_valid), 64'd0);
    chk("rst.Rw", 64'(Rw), 64'd0);
    chk("rst.busW", 64'(busW), 64'd0);
    chk("rst.RegWr", 64'(RegWr), 64'd0);
    chk("rst.misalign", 64'(misalign_err), 64'd0);
    chk("rst.instret", instret, 64'd0);
    #9;
    Rst = 1'b0;

    // ALU write
    drive(1, 1, 1, 2'b00, 32'h52B52B52, 0, 0, 3'b000, 0, 0);
    push("alu", 1, 1, 1, 32'h52B52B52, 0); tick();

    // load extraction
    drive(1, 2, 1, 2'b01, 32'h1001, 0, WORD, 3'b000, 0, 0);
    push("lb1", 1, 1, 2, 32'h0000007F, 0); tick();
    drive(1, 2, 1, 2'b01, 32'h1002, 0, WORD, 3'b000, 0, 0);
    push("lb2", 1, 1, 2, 32'hFFFFFFFF, 0); tick();
    drive(1, 2, 1, 2'b01, 32'h1003, 0, WORD, 3'b100, 0, 0);
    push("lbu3", 1, 1, 2, 32'h00000080, 0); tick();
    drive(1, 2, 1, 2'b01, 32'h1002, 0, WORD, 3'b001, 0, 0);
    push("lh2", 1, 1, 2, 32'hFFFF80FF, 0); tick();
    drive(1, 2, 1, 2'b01, 32'h1002, 0, WORD, 3'b101, 0, 0);
    push("lhu2", 1, 1, 2, 32'h000080FF, 0); tick();
    drive(1, 2, 1, 2'b01, 32'h1000, 0, WORD, 3'b010, 0, 0);
    push("lw0", 1, 1, 2, WORD, 0); tick();

    // misaligned / illegal loads
    drive(1, 3, 1, 2'b01, 32'h1002, 0, WORD, 3'b010, 0, 0);
    push("lw_mis", 1, 0, 3, WORD, 1); tick();
    drive(1, 3, 1, 2'b01, 32'h1001, 0, WORD, 3'b001, 0, 0);
    push("lh_mis", 1, 0, 3, 32'h00007F01, 1); tick();
    drive(1, 3, 1, 2'b01, 32'h1000, 0, WORD, 3'b011, 0, 0);
    push("f3_ill", 1, 0, 3, 32'h0, 1); tick();

    // x0, JAL link, reserved select
    drive(1, 0, 1, 2'b00, 32'hDEAD0000, 0, 0, 3'b000, 0, 0);
    push("x0", 1, 0, 0, 32'hDEAD0000, 0); tick();
    drive(1, 1, 1, 2'b10, 32'h200, 32'h104, 0, 3'b000, 0, 0);
    push("jal", 1, 1, 1, 32'h104, 0); tick();
    drive(1, 4, 1, 2'b11, 32'h0BAD_F00D, 32'h55, 0, 3'b000, 0, 0);
    push("sel11", 1, 1, 4, 32'h0BADF00D, 0); tick();
    drive(0, 7, 1, 2'b00, 32'h1234, 0, 0, 3'b000, 0, 0);
    push("bubble", 0, 0, 7, 32'h0, 0); tick();

    // stall for three edges on rd=5
    drive(1, 5, 1, 2'b00, 32'h55, 0, 0, 3'b000, 0, 0);
    push("st.cap", 1, 1, 5, 32'h55, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 1, 2'b00, 32'h99, 0, 0, 3'b000, 1, 0);
      push($sformatf("st.hold%0d", i), 1, 0, 5, 32'h55, 0); tick();
    end
    drive(0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0);
    push("st.rel", 0, 0, 0, 32'h0, 0); tick();

    // flush beats stall
    drive(1, 6, 1, 2'b00, 32'h66, 0, 0, 3'b000, 0, 0);
    push("fl.cap", 1, 1, 6, 32'h66, 0); tick();
    drive(1, 8, 1, 2'b00, 32'h88, 0, 0, 3'b000, 1, 1);
    push("fl.bub", 0, 0, 0, 32'h0, 0); tick();

    // async reset mid-cycle with a write pending
    drive(1, 4, 1, 2'b00, 32'h44, 0, 0, 3'b000, 0, 0);
    push("ar.cap", 1, 1, 4, 32'h44, 0); tick();
    #2;
    Rst = 1'b1;
    #1;
    chk("ar.RegWr", 64'(RegWr), 64'd0);
    chk("ar.wb_valid", 64'(wb_valid), 64'd0);
    chk("ar.busW", 64'(busW), 64'd0);
    chk("ar.Rw", 64'(Rw), 64'd0);
    chk("ar.instret", instret, 64'd0);
    @(posedge WrClk);
    #1;
    chk("ar.hold", 64'(RegWr), 64'd0);
    Rst = 1'b0;
    m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0; exp_ret = '0;
    drive(1, 3, 1, 2'b00, 32'h33, 0, 0, 3'b000, 0, 0);
    push("post", 1, 1, 3, 32'h33, 0); tick();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0);
    push("post2", 0, 0, 0, 32'h0, 0); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
